// File: rtl/gcn_pkg.sv
// rtl/gcn_pkg.sv - shared state/error types and defaults for the GCN layer sequencer
package gcn_pkg;

    localparam int DEF_FEATURE_ROWS      = 6;
    localparam int DEF_MAX_ADDRESS_WIDTH = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SET,
        CAPT,
        OUT,
        DONE,
        ERROR
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_TIMEOUT,
        ERR_PROTO
    } err_cause_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/gcn_watchdog.sv
// rtl/gcn_watchdog.sv - RUN-phase cycle watchdog; expired flags the TIMEOUT_CYCLES-th enabled cycle
module gcn_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMEOUT_WIDTH-1:0] count;

    // count holds the number of enabled cycles already completed
    assign expired = enable && (count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/gcn_layer_sequencer.sv
// rtl/gcn_layer_sequencer.sv - one GCN layer pass: clear, run with watchdog, stream per-node argmax
// Optional GCN_SEQ_PERF_EN adds perf_cycles (RUN cycle count of the last pass).
module gcn_layer_sequencer
    import gcn_pkg::*;
#(
    parameter int FEATURE_ROWS          = DEF_FEATURE_ROWS,
    parameter int MAX_ADDRESS_WIDTH     = DEF_MAX_ADDRESS_WIDTH,
    parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
    parameter int CLEAR_CYCLES          = 2,
    parameter int TIMEOUT_CYCLES        = 4096,
    parameter int TIMEOUT_WIDTH         = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      go,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      error,
    output logic                                      dp_reset,
    output logic                                      dp_start,
    input  logic                                      done_trans,
    input  logic                                      done_comb,
    output logic [COUNTER_FEATURE_WIDTH-1:0]          row_select,
    input  logic [FEATURE_ROWS*MAX_ADDRESS_WIDTH-1:0] max_addi_answer,
    output logic                                      result_valid,
    input  logic                                      result_ready,
    output logic [COUNTER_FEATURE_WIDTH-1:0]          result_row,
`ifdef GCN_SEQ_PERF_EN
    output logic [MAX_ADDRESS_WIDTH-1:0]              result_class,
    output logic [31:0]                               perf_cycles
`else
    output logic [MAX_ADDRESS_WIDTH-1:0]              result_class
`endif
);

    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
    localparam logic [COUNTER_FEATURE_WIDTH-1:0] LAST_ROW = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);

    seq_state_t                       state, state_nxt;
    err_cause_t                       err_cause;
    logic [CLR_W-1:0]                 clr_cnt;
    logic [COUNTER_FEATURE_WIDTH-1:0] row;
    logic                             trans_seen;
    logic                             go_accept;
    logic                             wd_expired;
    logic                             proto_err;
    logic [MAX_ADDRESS_WIDTH-1:0]     answer [FEATURE_ROWS];

    always_comb begin
        for (int r = 0; r < FEATURE_ROWS; r++) begin
            answer[r] = max_addi_answer[r*MAX_ADDRESS_WIDTH +: MAX_ADDRESS_WIDTH];
        end
    end

    gcn_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != RUN),
        .enable  (state == RUN),
        .expired (wd_expired)
    );

    assign go_accept = go && (state == IDLE || state == DONE || state == ERROR);
    // done_trans in the same cycle as done_comb counts as having seen it
    assign proto_err = (state == RUN) && done_comb && !(trans_seen || done_trans);

    assign busy         = (state != IDLE) && (state != ERROR);
    assign done         = (state == DONE);
    assign error        = (err_cause != ERR_NONE);
    assign dp_start     = (state == RUN);
    assign dp_reset     = (state == IDLE) || (state == CLEAR) || (state == ERROR);
    assign result_valid = (state == OUT);
    assign row_select   = (state == SET || state == CAPT || state == OUT) ? row : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (go_accept) state_nxt = CLEAR;
            CLEAR: if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) state_nxt = RUN;
            RUN: begin
                if (done_comb) begin
                    state_nxt = proto_err ? ERROR : SET;
                end else if (wd_expired) begin
                    state_nxt = ERROR;
                end
            end
            SET:   state_nxt = CAPT;
            CAPT:  state_nxt = OUT;
            OUT:   if (result_ready) state_nxt = (row == LAST_ROW) ? DONE : SET;
            DONE:  state_nxt = go_accept ? CLEAR : IDLE;
            ERROR: if (go_accept) state_nxt = CLEAR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            err_cause    <= ERR_NONE;
            clr_cnt      <= '0;
            row          <= '0;
            trans_seen   <= 1'b0;
            result_row   <= '0;
            result_class <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;

            if (state == RUN) begin
                trans_seen <= trans_seen || done_trans;
            end else begin
                trans_seen <= 1'b0;
            end

            if (state == RUN) begin
                row <= '0;
            end else if (state == OUT && result_ready && row != LAST_ROW) begin
                row <= row + 1'b1;
            end

            if (state == CAPT) begin
                result_row   <= row;
                result_class <= answer[row];
            end

            if (go_accept) begin
                err_cause <= ERR_NONE;
            end else if (proto_err) begin
                err_cause <= ERR_PROTO;
            end else if (state == RUN && !done_comb && wd_expired) begin
                err_cause <= ERR_TIMEOUT;
            end
        end
    end

`ifdef GCN_SEQ_PERF_EN
    logic [31:0] run_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt     <= '0;
            perf_cycles <= '0;
        end else begin
            run_cnt <= (state == RUN) ? sat_inc32(run_cnt) : '0;
            if (state == RUN && state_nxt != RUN) begin
                perf_cycles <= sat_inc32(run_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_gcn_layer_sequencer.sv
// tb/tb_gcn_layer_sequencer.sv - self-checking bench for gcn_layer_sequencer with a beat-queue model
module tb_gcn_layer_sequencer;

    localparam int FR  = 6;
    localparam int MAW = 2;
    localparam int CFW = 3;

    typedef struct {
        int row;
        int cls;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic go = 1'b0;
    logic w_go = 1'b0;
    logic done_trans = 1'b0;
    logic done_comb = 1'b0;
    logic result_ready = 1'b1;
    logic [FR*MAW-1:0] max_addi_answer = '0;

    logic busy, done, error, dp_reset, dp_start, result_valid;
    logic [CFW-1:0] row_select, result_row;
    logic [MAW-1:0] result_class;
    logic w_busy, w_done, w_error, w_dp_reset, w_dp_start, w_result_valid;
    logic [CFW-1:0] w_row_select, w_result_row;
    logic [MAW-1:0] w_result_class;
`ifdef GCN_SEQ_PERF_EN
    logic [31:0] perf_cycles, w_perf_cycles;
`endif

    int passed = 0;
    int total = 0;
    int done_cnt = 0;
    int beats = 0;
    int readout_cyc = 0;
    int run_cyc = 0;
    int t_trans = 9999;
    int t_comb = 9999;
    int rdy_phase = 0;
    bit ready_slow = 1'b0;
    bit mon_en = 1'b0;
    int ans [FR];
    beat_t exp_q [$];
    int got_cls [$];

    gcn_layer_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .go              (go),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .dp_reset        (dp_reset),
        .dp_start        (dp_start),
        .done_trans      (done_trans),
        .done_comb       (done_comb),
        .row_select      (row_select),
        .max_addi_answer (max_addi_answer),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_row      (result_row),
`ifdef GCN_SEQ_PERF_EN
        .perf_cycles     (perf_cycles),
`endif
        .result_class    (result_class)
    );

    gcn_layer_sequencer #(.TIMEOUT_CYCLES(16)) dut_wd (
        .clk             (clk),
        .reset           (reset),
        .go              (w_go),
        .busy            (w_busy),
        .done            (w_done),
        .error           (w_error),
        .dp_reset        (w_dp_reset),
        .dp_start        (w_dp_start),
        .done_trans      (1'b0),
        .done_comb       (1'b0),
        .row_select      (w_row_select),
        .max_addi_answer (max_addi_answer),
        .result_valid    (w_result_valid),
        .result_ready    (result_ready),
        .result_row      (w_result_row),
`ifdef GCN_SEQ_PERF_EN
        .perf_cycles     (w_perf_cycles),
`endif
        .result_class    (w_result_class)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input longint act, input longint expv);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // datapath stand-in: done pulses at fixed RUN-cycle numbers (1 = first RUN cycle)
    always @(negedge clk) begin
        run_cyc    = dp_start ? run_cyc + 1 : 0;
        done_trans = (run_cyc == t_trans);
        done_comb  = (run_cyc == t_comb);
    end

    always @(posedge clk) begin
        #1;
        rdy_phase    = (rdy_phase + 1) % 3;
        result_ready = ready_slow ? (rdy_phase == 0) : 1'b1;
    end

    // model compare: every shown beat must equal the queue head until it is accepted
    always @(negedge clk) begin
        if (mon_en) begin
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_beat", result_row, -1);
                end else begin
                    check(result_row == CFW'(exp_q[0].row), "beat_row", result_row, exp_q[0].row);
                    check(result_class == MAW'(exp_q[0].cls), "beat_class", result_class, exp_q[0].cls);
                    check(row_select == result_row, "row_select_hold", row_select, result_row);
                    if (result_ready) begin
                        got_cls.push_back(int'(result_class));
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
            end
            if (done) begin
                check(exp_q.size() == 0, "done_with_beats_left", exp_q.size(), 0);
                check(busy, "busy_in_done", busy, 1);
                done_cnt++;
            end
            if (busy && !dp_start && !dp_reset && !done) readout_cyc++;
            check(!(dp_start && dp_reset), "start_reset_excl", {dp_start, dp_reset}, 0);
        end
    end

    task automatic check_reset_vals(input string tag);
        check(busy == 1'b0 && done == 1'b0 && error == 1'b0, {tag, "_flags"}, {busy, done, error}, 0);
        check(dp_reset == 1'b1 && dp_start == 1'b0, {tag, "_dp"}, {dp_reset, dp_start}, 2);
        check(result_valid == 1'b0 && row_select == '0, {tag, "_valid_row"}, {result_valid, row_select}, 0);
        check(result_row == '0 && result_class == '0, {tag, "_result"}, {result_row, result_class}, 0);
    endtask

    task automatic load_answers();
        exp_q.delete();
        for (int r = 0; r < FR; r++) begin
            max_addi_answer[r*MAW +: MAW] = MAW'(ans[r]);
            exp_q.push_back('{row: r, cls: ans[r]});
        end
    endtask

    task automatic start_go(input string tag);
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        check(busy && dp_reset && !dp_start && !error, {tag, "_clear1"}, {busy, dp_reset, dp_start, error}, 4'b1100);
        @(posedge clk); #1;
        check(dp_reset && !dp_start, {tag, "_clear2"}, {dp_reset, dp_start}, 2'b10);
        @(posedge clk); #1;
        check(dp_start && !dp_reset, {tag, "_run_enter"}, {dp_reset, dp_start}, 2'b01);
    endtask

    task automatic run_pass(input int tt, input int tc, input bit slow, input bit inject, input string tag);
        int d0, b0;
        bit g1, g2;
        t_trans = tt; t_comb = tc; ready_slow = slow;
        load_answers();
        d0 = done_cnt; b0 = beats; readout_cyc = 0; g1 = 0; g2 = 0;
        start_go(tag);
        for (int i = 0; i < 2000 && done_cnt == d0; i++) begin
            @(posedge clk); #1;
            go = 1'b0;
            if (inject && dp_start && !g1) begin
                go = 1'b1; g1 = 1'b1;
            end else if (inject && result_valid && result_row == 3'd2 && !g2) begin
                go = 1'b1; g2 = 1'b1;
            end
        end
        go = 1'b0;
        check(done_cnt - d0 == 1, {tag, "_done_seen"}, done_cnt - d0, 1);
        check(beats - b0 == FR, {tag, "_beat_count"}, beats - b0, FR);
        if (!slow) check(readout_cyc == 3 * FR, {tag, "_readout_cycles"}, readout_cyc, 3 * FR);
        repeat (3) @(posedge clk);
        #1;
        check(!busy && !error, {tag, "_idle_after"}, {busy, error}, 0);
        check(done_cnt - d0 == 1, {tag, "_single_done"}, done_cnt - d0, 1);
`ifdef GCN_SEQ_PERF_EN
        check(perf_cycles == 32'(tc), {tag, "_perf"}, perf_cycles, tc);
`endif
    endtask

    initial begin
        int n, d0, b0;
        int lit1 [FR] = '{1, 0, 2, 2, 1, 0};

        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b1;
        mon_en = 1'b1;

        // 1: nominal pass, ready tied high
        ans = '{1, 0, 2, 2, 1, 0};
        got_cls.delete();
        run_pass(40, 60, 1'b0, 1'b0, "s1");
        check(got_cls.size() == FR, "s1_lit_count", got_cls.size(), FR);
        for (int r = 0; r < FR && r < got_cls.size(); r++)
            check(got_cls[r] == lit1[r], "s1_lit_class", got_cls[r], lit1[r]);

        // 2: ready 1-in-3
        run_pass(40, 60, 1'b1, 1'b0, "s2");
        ready_slow = 1'b0;

        // 3: watchdog timeout with TIMEOUT_CYCLES=16
        @(posedge clk); #1 w_go = 1'b1;
        @(posedge clk); #1 w_go = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && !w_error; i++) begin
            @(posedge clk); #1;
            if (w_dp_start) n++;
        end
        check(n == 16, "s3_run_cycles", n, 16);
        check(w_error && !w_dp_start && w_dp_reset && !w_busy, "s3_error_state",
              {w_error, w_dp_start, w_dp_reset, w_busy}, 4'b1010);
        check(!w_done && !w_result_valid && w_row_select == '0, "s3_quiet",
              {w_done, w_result_valid, w_row_select}, 0);
        @(posedge clk); #1 w_go = 1'b1;
        @(posedge clk); #1 w_go = 1'b0;
        check(!w_error && w_busy, "s3_restart", {w_error, w_busy}, 2'b01);

        // 4: protocol error, then same-cycle done_trans/done_comb
        t_trans = 9999; t_comb = 20;
        exp_q.delete();
        d0 = done_cnt; b0 = beats;
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && !error; i++) begin
            @(posedge clk); #1;
            if (dp_start) n++;
        end
        check(n == 20, "s4_proto_run_cycles", n, 20);
        repeat (4) @(posedge clk);
        #1;
        check(error && !dp_start && dp_reset && !busy, "s4_proto_error",
              {error, dp_start, dp_reset, busy}, 4'b1010);
        check(beats == b0 && done_cnt == d0, "s4_no_output", beats - b0 + done_cnt - d0, 0);
`ifdef GCN_SEQ_PERF_EN
        check(perf_cycles == 32'd20, "s4_perf_on_error", perf_cycles, 20);
`endif
        ans = '{3, 2, 1, 0, 3, 2};
        run_pass(30, 30, 1'b0, 1'b0, "s4_same");

        // 5: reset during OUT of row 3
        ans = '{2, 3, 0, 1, 1, 3};
        t_trans = 40; t_comb = 60;
        load_answers();
        d0 = done_cnt;
        start_go("s5");
        for (int i = 0; i < 300 && !(result_valid && result_row == 3'd3); i++) begin
            @(posedge clk); #1;
        end
        check(result_valid && result_row == 3'd3, "s5_reach_row3", result_row, 3);
        reset = 1'b0;
        #1;
        check_reset_vals("s5_async");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check(done_cnt == d0, "s5_no_done", done_cnt - d0, 0);
        run_pass(40, 60, 1'b0, 1'b0, "s5_after");

        // 6: go pulses during RUN and OUT are ignored
        ans = '{1, 0, 2, 2, 1, 0};
        run_pass(40, 60, 1'b0, 1'b1, "s6");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
